// File: rtl/halt_controller.sv
// Run/drain/halt sequencer between the core and the cycle counter.
// Optional watchdog compare is compiled in with HALT_CONTROLLER_WATCHDOG_EN.
module halt_controller #(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop_req,
  input  logic [15:0] cycle_count,
  input  logic [15:0] limit,
  input  logic        limit_en,
  output logic        run,
  output logic        halt,
  output logic        done,
  output logic        timeout,
  output logic [15:0] final_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

  localparam int unsigned CNT_W     = 4;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam bit          NO_DRAIN  = (DRAIN_CYCLES == 0);

  state_t           state;
  logic [CNT_W-1:0] drainCnt;
  logic             limitHit;
  logic             endRun;

`ifdef HALT_CONTROLLER_WATCHDOG_EN
  assign limitHit = limit_en && (cycle_count >= limit);
`else
  // Watchdog inputs are kept on the interface but have no effect in this build.
  logic unusedWatchdog;
  assign unusedWatchdog = ^{limit, limit_en};
  assign limitHit       = 1'b0;
  assign timeout        = 1'b0;
`endif

  assign endRun = stop_req || limitHit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      run         <= 1'b0;
      halt        <= 1'b0;
      done        <= 1'b0;
      final_count <= 16'h0000;
      drainCnt    <= '0;
`ifdef HALT_CONTROLLER_WATCHDOG_EN
      timeout     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            run   <= 1'b1;
          end
        end
        RUN: begin
          if (endRun) begin
            run <= 1'b0;
`ifdef HALT_CONTROLLER_WATCHDOG_EN
            // A core halt request wins over a coincident limit hit.
            if (!stop_req) timeout <= 1'b1;
`endif
            if (NO_DRAIN) begin
              state       <= HALTED;
              halt        <= 1'b1;
              done        <= 1'b1;
              final_count <= cycle_count;
            end else begin
              state    <= DRAIN;
              drainCnt <= DRAIN_LOAD;
            end
          end
        end
        DRAIN: begin
          if (drainCnt == CNT_W'(0)) begin
            state       <= HALTED;
            halt        <= 1'b1;
            done        <= 1'b1;
            final_count <= cycle_count;
          end else begin
            drainCnt <= drainCnt - CNT_W'(1);
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_halt_controller.sv
// Directed bench for halt_controller: a DRAIN_CYCLES=2 and a DRAIN_CYCLES=0
// instance share stimulus; the watchdog section follows the build macro.
module tb_halt_controller;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop_req;
  logic [15:0] cycle_count;
  logic [15:0] limit;
  logic        limit_en;

  logic        runD2, haltD2, doneD2, timeoutD2;
  logic [15:0] finalD2;
  logic        runD0, haltD0, doneD0, timeoutD0;
  logic [15:0] finalD0;

  int checkCount = 0;
  int errorCount = 0;

  halt_controller #(.DRAIN_CYCLES(2)) dutD2 (
    .clk(clk), .rst(rst), .start(start), .stop_req(stop_req),
    .cycle_count(cycle_count), .limit(limit), .limit_en(limit_en),
    .run(runD2), .halt(haltD2), .done(doneD2), .timeout(timeoutD2),
    .final_count(finalD2)
  );

  halt_controller #(.DRAIN_CYCLES(0)) dutD0 (
    .clk(clk), .rst(rst), .start(start), .stop_req(stop_req),
    .cycle_count(cycle_count), .limit(limit), .limit_en(limit_en),
    .run(runD0), .halt(haltD0), .done(doneD0), .timeout(timeoutD0),
    .final_count(finalD0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst         = 1'b0;
    start       = 1'b0;
    stop_req    = 1'b0;
    limit_en    = 1'b0;
    limit       = 16'h0000;
    cycle_count = 16'h0000;
    #3;
    rst = 1'b1;
  endtask

  task automatic startRun();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop_req = 1'b0;
    limit_en = 1'b0; limit = 16'h0000; cycle_count = 16'h0000;
    #2;
    check("rst_run", 16'(runD2), 16'h0);
    check("rst_halt", 16'(haltD2), 16'h0);
    check("rst_done", 16'(doneD2), 16'h0);
    check("rst_timeout", 16'(timeoutD2), 16'h0);
    check("rst_final", finalD2, 16'h0000);
    tick();
    rst = 1'b1;

    // Stop ignored in IDLE
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    check("idle_stop_ignored", 16'(runD2), 16'h0);
    check("idle_no_halt", 16'(haltD2), 16'h0);

    // Normal stop with 2-cycle drain; DRAIN_CYCLES=0 instance halts at once
    startRun();
    check("run_up", 16'(runD2), 16'h1);
    check("run_up_d0", 16'(runD0), 16'h1);
    cycle_count = 16'h0040;
    stop_req    = 1'b1;
    tick();
    stop_req = 1'b0;
    check("drain_run_low", 16'(runD2), 16'h0);
    check("drain_halt_low", 16'(haltD2), 16'h0);
    check("drain_done_low", 16'(doneD2), 16'h0);
    check("d0_run_low", 16'(runD0), 16'h0);
    check("d0_halt", 16'(haltD0), 16'h1);
    check("d0_done", 16'(doneD0), 16'h1);
    check("d0_final", finalD0, 16'h0040);
    cycle_count = 16'h0041;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("drain2_halt_low", 16'(haltD2), 16'h0);
    check("drain2_run_low", 16'(runD2), 16'h0);
    check("d0_done_once", 16'(doneD0), 16'h0);
    cycle_count = 16'h0042;
    tick();
    check("halt_set", 16'(haltD2), 16'h1);
    check("done_pulse", 16'(doneD2), 16'h1);
    check("final_cnt", finalD2, 16'h0042);
    check("no_timeout", 16'(timeoutD2), 16'h0);
    cycle_count = 16'h0043;
    start = 1'b1; stop_req = 1'b1;
    tick();
    start = 1'b0; stop_req = 1'b0;
    check("done_cleared", 16'(doneD2), 16'h0);
    check("halt_sticky", 16'(haltD2), 16'h1);
    check("halted_no_run", 16'(runD2), 16'h0);
    check("final_stable", finalD2, 16'h0042);

    // Reset pulse mid-DRAIN aborts without a done pulse
    doReset();
    tick();
    startRun();
    cycle_count = 16'h0020;
    stop_req    = 1'b1;
    tick();
    stop_req = 1'b0;
    check("pre_abort_d0_final", finalD0, 16'h0020);
    #3 rst = 1'b0;
    #1;
    check("abort_run", 16'(runD2), 16'h0);
    check("abort_halt", 16'(haltD2), 16'h0);
    check("abort_done", 16'(doneD2), 16'h0);
    check("abort_d0_halt", 16'(haltD0), 16'h0);
    check("abort_d0_final", finalD0, 16'h0000);
    #2 rst = 1'b1;
    tick();
    tick();
    tick();
    check("post_abort_done", 16'(doneD2), 16'h0);
    check("post_abort_halt", 16'(haltD2), 16'h0);
    check("post_abort_run", 16'(runD2), 16'h0);
    startRun();
    check("restart_run", 16'(runD2), 16'h1);

`ifdef HALT_CONTROLLER_WATCHDOG_EN
    // Watchdog hit at cycle_count == limit
    doReset();
    tick();
    limit_en = 1'b1;
    limit    = 16'h0100;
    cycle_count = 16'h00FE;
    startRun();
    cycle_count = 16'h00FF;
    tick();
    check("wd_below_run", 16'(runD2), 16'h1);
    check("wd_below_to", 16'(timeoutD2), 16'h0);
    cycle_count = 16'h0100;
    tick();
    check("wd_hit_run", 16'(runD2), 16'h0);
    check("wd_hit_to", 16'(timeoutD2), 16'h1);
    check("wd_hit_halt", 16'(haltD2), 16'h0);
    cycle_count = 16'h0101;
    limit_en = 1'b0;
    tick();
    cycle_count = 16'h0102;
    tick();
    check("wd_halt", 16'(haltD2), 16'h1);
    check("wd_done", 16'(doneD2), 16'h1);
    check("wd_final", finalD2, 16'h0102);
    check("wd_to_sticky", 16'(timeoutD2), 16'h1);

    // Coincident stop and limit hit counts as a plain stop
    doReset();
    tick();
    startRun();
    limit_en = 1'b1; limit = 16'h0010; cycle_count = 16'h0010; stop_req = 1'b1;
    tick();
    stop_req = 1'b0; limit_en = 1'b0;
    check("tie_to", 16'(timeoutD2), 16'h0);
    check("tie_run", 16'(runD2), 16'h0);
    tick();
    tick();
    check("tie_halt", 16'(haltD2), 16'h1);
    check("tie_to_final", 16'(timeoutD2), 16'h0);

    // limit=0 times out on the first RUN cycle
    doReset();
    tick();
    limit_en = 1'b1; limit = 16'h0000; cycle_count = 16'h0003;
    startRun();
    check("lim0_run", 16'(runD2), 16'h1);
    check("lim0_to_early", 16'(timeoutD2), 16'h0);
    tick();
    check("lim0_to", 16'(timeoutD2), 16'h1);
    check("lim0_run_low", 16'(runD2), 16'h0);
`else
    // Watchdog compiled out: limit ignored, stop still halts
    doReset();
    tick();
    limit_en = 1'b1;
    limit    = 16'h0005;
    startRun();
    for (int i = 0; i < 256; i++) begin
      cycle_count = 16'(i);
      tick();
    end
    check("nowd_run", 16'(runD2), 16'h1);
    check("nowd_to", 16'(timeoutD2), 16'h0);
    check("nowd_halt", 16'(haltD2), 16'h0);
    stop_req = 1'b1;
    cycle_count = 16'h0100;
    tick();
    stop_req = 1'b0;
    check("nowd_stop_run", 16'(runD2), 16'h0);
    tick();
    tick();
    check("nowd_halt_set", 16'(haltD2), 16'h1);
    check("nowd_to_final", 16'(timeoutD2), 16'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/halt_controller.md
HALT_CONTROLLER -- requirements
Module: halt_controller

Interface
REQ-001 Parameter: DRAIN_CYCLES, default 2, cycles to wait between stop decision and halt assertion (0..15).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  level, sampled each cycle; requests run from IDLE.
REQ-005 stop_req  input  1  level, sampled each cycle; core halt request (halt instruction).
REQ-006 cycle_count  input  16  running cycle count from the cycle counter.
REQ-007 limit  input  16  watchdog cycle limit.
REQ-008 limit_en  input  1  enables the watchdog compare.
REQ-009 run  output  1  core execution enable.
REQ-010 halt  output  1  halt strobe to the cycle counter; sticky once high.
REQ-011 done  output  1  one-cycle pulse on entry to HALTED.
REQ-012 timeout  output  1  sticky; halt caused by watchdog.
REQ-013 final_count  output  16  cycle_count captured on entry to HALTED.

Function
REQ-014 The block SHALL implement states IDLE, RUN, DRAIN, HALTED, encoded in a registered state machine.
REQ-015 IDLE: run=0, halt=0; start=1 SHALL move to RUN next edge; stop_req ignored in IDLE.
REQ-016 RUN: run=1, halt=0; stop_req=1 SHALL end the run with timeout staying 0.
REQ-017 RUN: limit_en=1 and cycle_count >= limit (unsigned 16-bit) with stop_req=0 SHALL end the run and set timeout=1 on the same edge.
REQ-018 Simultaneous stop_req and limit hit SHALL be treated as stop_req (timeout stays 0).
REQ-019 Ending a run SHALL go to DRAIN loading a 4-bit down-counter with DRAIN_CYCLES-1, or directly to HALTED when DRAIN_CYCLES=0.
REQ-020 DRAIN: run=0, halt=0; counter decrements each cycle; at 0 SHALL move to HALTED next edge (DRAIN occupies exactly DRAIN_CYCLES cycles).
REQ-021 stop_req, start, and limit changes during DRAIN SHALL be ignored.
REQ-022 On the edge entering HALTED: final_count <= cycle_count, done=1 for exactly one cycle.
REQ-023 HALTED: run=0, halt=1; state held until reset; start and stop_req ignored; final_count stable.
REQ-024 halt SHALL be a registered output (glitch-free), high from the first HALTED cycle.
REQ-025 limit=0 with limit_en=1 SHALL cause timeout on the first RUN cycle.

Reset
REQ-026 rst=0 SHALL immediately force state=IDLE, run=0, halt=0, done=0, timeout=0, final_count=16'h0000, drain counter=0, independent of clk.
REQ-027 Reset asserted in any state, including mid-DRAIN, SHALL abort the operation with no done pulse.
REQ-028 After rst deassertion, the first state change SHALL occur no earlier than the next rising edge.

Configuration
REQ-029 Macro HALT_CONTROLLER_WATCHDOG_EN defined: comparator, timeout register and REQ-017/018/025 behaviour compiled in.
REQ-030 Macro undefined: limit and limit_en ports SHALL remain present but be ignored, timeout tied to 0, and runs end only by stop_req.

Verification
REQ-031 Reset, start=1 one cycle, stop_req=1 at cycle_count=16'h0040, DRAIN_CYCLES=2 -> run falls next edge, halt=1 and done pulse exactly 3 edges after stop_req sampled, final_count=16'h0042 (counter advancing), timeout=0.
REQ-032 limit_en=1, limit=16'h0100, no stop_req -> at cycle_count=16'h0100 timeout=1, halt=1 after DRAIN, final_count=16'h0102.
REQ-033 stop_req=1 and cycle_count=limit=16'h0010 on the same cycle -> timeout=0, normal halt sequence.
REQ-034 DRAIN_CYCLES=0, stop_req in RUN -> halt=1 and done=1 on the very next edge, run=0 same edge.
REQ-035 rst=0 pulsed mid-DRAIN (between edges) -> outputs zero immediately, no done pulse, start then restarts normally from IDLE.
REQ-036 Macro undefined, limit_en=1, limit=16'h0005 -> no timeout after 16'h0100 cycles; stop_req still halts, timeout=0.
